// File: rtl/lfsr_search_decrypter.sv
// lfsr_search_decrypter
//
// Recovers an LFSR seed from the padded preamble of an encrypted message held
// in a shared data memory. It then searches a table of candidate tap patterns
// for the first one whose keystream reproduces the preamble. With that
// pattern it decrypts the message, drops every leading pad byte, and writes
// the packed plaintext back to memory, topped up with pad bytes.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   init        asynchronous active-high reset; a run starts on the first
//               rising clk after it falls
//   mem_raddr   read address (registered)
//   mem_rdata   read data, valid one cycle after mem_raddr is presented
//   mem_wr_en   write strobe (registered)
//   mem_waddr   write address
//   mem_wdata   write data
//   done        run finished, held until init
//   match       a tap pattern was found (valid when done)
//   found_pat   index of the matching tap pattern
//   found_seed  recovered LFSR start state
//   pre_len     number of leading pad bytes stripped
//
// MIN_PRE must be at least 2 so that the first preamble byte is already
// buffered when the seed is checked at the end of the load phase.

module lfsr_search_decrypter #(
    parameter int                        LFSR_W   = 5,
    parameter int                        PAT_CNT  = 6,
    parameter logic [PAT_CNT*LFSR_W-1:0] TAPS     = {5'h12, 5'h14, 5'h17, 5'h1B, 5'h1D, 5'h1E},
    parameter int                        MSG_LEN  = 64,
    parameter int                        MIN_PRE  = 7,
    parameter logic [7:0]                PAD_CHAR = 8'h7E,
    parameter int                        ADDR_W   = 8,
    parameter int                        SRC_BASE = 128,
    parameter int                        DST_BASE = 192
) (
    input  logic                         clk,
    input  logic                         init,
    output logic [ADDR_W-1:0]            mem_raddr,
    input  logic [7:0]                   mem_rdata,
    output logic                         mem_wr_en,
    output logic [ADDR_W-1:0]            mem_waddr,
    output logic [7:0]                   mem_wdata,
    output logic                         done,
    output logic                         match,
    output logic [$clog2(PAT_CNT)-1:0]   found_pat,
    output logic [LFSR_W-1:0]            found_seed,
    output logic [$clog2(MSG_LEN+1)-1:0] pre_len
);

    localparam int PAT_W = $clog2(PAT_CNT);
    localparam int CNT_W = $clog2(MSG_LEN + 1);
    localparam int IDX_W = $clog2(MIN_PRE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEARCH,
        S_DECRYPT,
        S_FILL,
        S_FINISH
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  wr_idx;
    logic [7:0]        pre_buf [MIN_PRE];
    logic [PAT_W-1:0]  pat_idx;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] run_taps;
    logic              seen_data;

    logic [LFSR_W-1:0] seed_c;
    logic              seed_ok;
    logic [LFSR_W-1:0] cur_taps;
    logic [LFSR_W-1:0] ks;
    logic              pat_hit;
    logic [7:0]        plain;
    logic              dec_valid;
    logic              dec_write;
    logic [CNT_W-1:0]  wr_idx_next;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] t);
        return {s[LFSR_W-2:0], ^(s & t)};
    endfunction

    // Seed recovery and the unrolled preamble check for the pattern under test.
    // The upper bits of the first byte carry no keystream, so they must equal
    // the pad character; a zero seed would give a constant-zero keystream.
    always_comb begin
        seed_c   = LFSR_W'(pre_buf[0] ^ PAD_CHAR);
        seed_ok  = (((pre_buf[0] ^ PAD_CHAR) >> LFSR_W) == 8'd0) && (seed_c != '0);
        cur_taps = TAPS[int'(pat_idx) * LFSR_W +: LFSR_W];
        ks       = seed_c;
        pat_hit  = 1'b1;
        for (int i = 0; i < MIN_PRE; i++) begin
            if (pre_buf[i] != (PAD_CHAR ^ 8'(ks)))
                pat_hit = 1'b0;
            ks = lfsr_step(ks, cur_taps);
        end
    end

    // Decrypt-path decode. Read data is one cycle behind the address, so
    // byte cnt-1 arrives while cnt is non-zero. Pad bytes are dropped only
    // until the first real character has been seen.
    always_comb begin
        plain       = mem_rdata ^ 8'(lfsr);
        dec_valid   = (state == S_DECRYPT) && (cnt != '0);
        dec_write   = dec_valid && (seen_data || (plain != PAD_CHAR));
        wr_idx_next = wr_idx + CNT_W'(dec_write);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = S_LOAD;
            S_LOAD:
                if (cnt == CNT_W'(MIN_PRE))
                    state_next = seed_ok ? S_SEARCH : S_FINISH;
            S_SEARCH:
                if (pat_hit)
                    state_next = S_DECRYPT;
                else if (pat_idx == PAT_W'(PAT_CNT - 1))
                    state_next = S_FINISH;
            S_DECRYPT:
                if (cnt == CNT_W'(MSG_LEN))
                    state_next = (wr_idx_next < CNT_W'(MSG_LEN)) ? S_FILL : S_FINISH;
            S_FILL:
                if (wr_idx == CNT_W'(MSG_LEN - 1))
                    state_next = S_FINISH;
            S_FINISH: state_next = S_FINISH;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Datapath and registered memory interface. The write strobe is a
    // one-cycle pulse per byte and is cleared by default every cycle.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            mem_raddr  <= '0;
            mem_wr_en  <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            match      <= 1'b0;
            found_pat  <= '0;
            found_seed <= '0;
            pre_len    <= '0;
            cnt        <= '0;
            wr_idx     <= '0;
            pat_idx    <= '0;
            lfsr       <= '0;
            run_taps   <= '0;
            seen_data  <= 1'b0;
            for (int i = 0; i < MIN_PRE; i++)
                pre_buf[i] <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    mem_raddr <= ADDR_W'(SRC_BASE);
                    cnt       <= '0;
                end
                S_LOAD: begin
                    mem_raddr <= ADDR_W'(SRC_BASE) + ADDR_W'(cnt) + ADDR_W'(1);
                    if (cnt != '0)
                        pre_buf[IDX_W'(cnt - 1'b1)] <= mem_rdata;
                    cnt     <= cnt + 1'b1;
                    pat_idx <= '0;
                end
                S_SEARCH: begin
                    if (pat_hit) begin
                        match      <= 1'b1;
                        found_pat  <= pat_idx;
                        found_seed <= seed_c;
                        lfsr       <= seed_c;
                        run_taps   <= cur_taps;
                        mem_raddr  <= ADDR_W'(SRC_BASE);
                        cnt        <= '0;
                        wr_idx     <= '0;
                        seen_data  <= 1'b0;
                    end else begin
                        pat_idx <= pat_idx + 1'b1;
                    end
                end
                S_DECRYPT: begin
                    mem_raddr <= ADDR_W'(SRC_BASE) + ADDR_W'(cnt) + ADDR_W'(1);
                    cnt       <= cnt + 1'b1;
                    if (dec_valid) begin
                        lfsr <= lfsr_step(lfsr, run_taps);
                        if (dec_write) begin
                            mem_wr_en <= 1'b1;
                            mem_waddr <= ADDR_W'(DST_BASE) + ADDR_W'(wr_idx);
                            mem_wdata <= plain;
                            wr_idx    <= wr_idx_next;
                            seen_data <= 1'b1;
                        end else begin
                            pre_len <= pre_len + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    mem_wr_en <= 1'b1;
                    mem_waddr <= ADDR_W'(DST_BASE) + ADDR_W'(wr_idx);
                    mem_wdata <= PAD_CHAR;
                    wr_idx    <= wr_idx + 1'b1;
                end
                S_FINISH: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
